// File: rtl/sfifo_cmd_sched.sv
// ---------------------------------------------------------------------------
// sfifo_cmd_sched
//
// Command sequencer for the sync-FIFO datapath. It pops 16-bit command words
// from a show-ahead SFIFO and executes them in order:
//   cmd[15:14] = 00  NOP
//              = 01  DOUT     : dout_o[cmd[2:0]] <= cmd[13]
//              = 10  WAIT_BP  : wait for cmd[7:0] base-period ticks
//              = 11  WAIT_DIN : wait until din[cmd[3:0]] == cmd[12], or timeout
//
// Ports:
//   wb_clk_i         clock, all logic on posedge
//   wb_rst_ni        asynchronous active-low reset
//   enable_i         1 = fetch/execute, 0 = stop fetching and abort waits
//   clr_i            single-cycle pulse clearing timeout_o
//   sfifo_rd_o       pop strobe, one cycle per command
//   sfifo_empty_i    SFIFO empty flag
//   sfifo_di         head-of-FIFO word (show-ahead)
//   sfifo_bp_tick_i  base-period tick level from a slower domain
//   din_i            asynchronous digital inputs
//   dout_o           digital outputs
//   busy_o           high whenever the sequencer is not idle
//   timeout_o        sticky WAIT_DIN timeout flag
//   cmd_cnt_o        executed-command count, wraps
// ---------------------------------------------------------------------------
module sfifo_cmd_sched #(
    parameter int SFIFO_DW = 16,
    parameter int TIMEOUT  = 1000,
    parameter int TO_W     = 16,
    parameter int CNT_W    = 16
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_ni,
    input  logic                enable_i,
    input  logic                clr_i,
    output logic                sfifo_rd_o,
    input  logic                sfifo_empty_i,
    input  logic [SFIFO_DW-1:0] sfifo_di,
    input  logic                sfifo_bp_tick_i,
    input  logic [15:0]         din_i,
    output logic [7:0]          dout_o,
    output logic                busy_o,
    output logic                timeout_o,
    output logic [CNT_W-1:0]    cmd_cnt_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DECODE   = 2'd1,
        WAIT_BP  = 2'd2,
        WAIT_DIN = 2'd3
    } state_t;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_DOUT = 2'b01;
    localparam logic [1:0] OP_WBP  = 2'b10;
    localparam logic [1:0] OP_WDIN = 2'b11;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_t             state_reg,   state_next;
    logic [15:0]        cmd_reg,     cmd_next;
    logic               rd_reg,      rd_next;
    logic [7:0]         dout_reg,    dout_next;
    logic               timeout_reg, timeout_next;
    logic [CNT_W-1:0]   cnt_reg,     cnt_next;
    logic [7:0]         bp_cnt_reg,  bp_cnt_next;
    logic [TO_W-1:0]    to_cnt_reg,  to_cnt_next;

    logic               bp_sync_reg;
    logic               bp_prev_reg;
    logic               bp_pulse;
    logic [15:0]        din_meta_reg;
    logic [15:0]        din_sync_reg;

    logic               done;       // current command finished, bump counter
    logic               dout_we;    // apply the DOUT action this edge
    logic               to_set;     // WAIT_DIN expired without a match

    // Command fields
    logic [1:0]         op;
    logic [2:0]         pin;
    logic               pin_val;
    logic [7:0]         bp_n;
    logic               din_level;
    logic [3:0]         din_idx;
    logic               unused_cmd_bits;

    assign op        = cmd_reg[15:14];
    assign pin_val   = cmd_reg[13];
    assign din_level = cmd_reg[12];
    assign bp_n      = cmd_reg[7:0];
    assign din_idx   = cmd_reg[3:0];
    assign pin       = cmd_reg[2:0];
    assign unused_cmd_bits = ^cmd_reg[11:8];

    // Base-period tick: single synchroniser flop, then rising-edge detect.
    assign bp_pulse = bp_sync_reg & ~bp_prev_reg;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            bp_sync_reg <= 1'b0;
            bp_prev_reg <= 1'b0;
        end else begin
            bp_sync_reg <= sfifo_bp_tick_i;
            bp_prev_reg <= bp_sync_reg;
        end
    end

    // Two-flop synchroniser per DIN bit.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_din_sync
            always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
                if (!wb_rst_ni) begin
                    din_meta_reg[gi] <= 1'b0;
                    din_sync_reg[gi] <= 1'b0;
                end else begin
                    din_meta_reg[gi] <= din_i[gi];
                    din_sync_reg[gi] <= din_meta_reg[gi];
                end
            end
        end
    endgenerate

    // Per-pin output update; untouched pins always hold.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_dout
            assign dout_next[gi] = (dout_we && (pin == 3'(gi))) ? pin_val : dout_reg[gi];
        end
    endgenerate

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_reg   <= IDLE;
            cmd_reg     <= 16'h0000;
            rd_reg      <= 1'b0;
            dout_reg    <= 8'h00;
            timeout_reg <= 1'b0;
            cnt_reg     <= '0;
            bp_cnt_reg  <= 8'h00;
            to_cnt_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            cmd_reg     <= cmd_next;
            rd_reg      <= rd_next;
            dout_reg    <= dout_next;
            timeout_reg <= timeout_next;
            cnt_reg     <= cnt_next;
            bp_cnt_reg  <= bp_cnt_next;
            to_cnt_reg  <= to_cnt_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cmd_next    = cmd_reg;
        rd_next     = 1'b0;
        bp_cnt_next = bp_cnt_reg;
        to_cnt_next = to_cnt_reg;
        done        = 1'b0;
        dout_we     = 1'b0;
        to_set      = 1'b0;

        case (state_reg)
            IDLE: begin
                // rd_reg guard keeps a stale head word from being popped twice.
                if (enable_i && !sfifo_empty_i && !rd_reg) begin
                    cmd_next   = sfifo_di[15:0];
                    rd_next    = 1'b1;
                    state_next = DECODE;
                end
            end

            DECODE: begin
                // A latched command always completes, even if enable_i dropped.
                case (op)
                    OP_NOP: begin
                        done = 1'b1;
                    end
                    OP_DOUT: begin
                        dout_we = 1'b1;
                        done    = 1'b1;
                    end
                    OP_WBP: begin
                        if (bp_n == 8'h00) begin
                            done = 1'b1;
                        end else begin
                            bp_cnt_next = bp_n;
                            state_next  = WAIT_BP;
                        end
                    end
                    OP_WDIN: begin
                        to_cnt_next = '0;
                        state_next  = WAIT_DIN;
                    end
                    default: begin
                        done = 1'b1;
                    end
                endcase
            end

            WAIT_BP: begin
                if (!enable_i) begin
                    state_next = IDLE;
                end else if (bp_pulse) begin
                    if (bp_cnt_reg == 8'h01) begin
                        done = 1'b1;
                    end else begin
                        bp_cnt_next = bp_cnt_reg - 8'h01;
                    end
                end
            end

            WAIT_DIN: begin
                // A match is tested before the timeout so it wins a tie.
                if (!enable_i) begin
                    state_next = IDLE;
                end else if (din_sync_reg[din_idx] == din_level) begin
                    done = 1'b1;
                end else if (to_cnt_reg == TO_LAST) begin
                    to_set = 1'b1;
                    done   = 1'b1;
                end else begin
                    to_cnt_next = to_cnt_reg + 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        if (done) begin
            state_next = IDLE;
        end
    end

    assign cnt_next = done ? cnt_reg + 1'b1 : cnt_reg;

    // Setting the flag takes priority over a coincident clear.
    assign timeout_next = to_set ? 1'b1 : (clr_i ? 1'b0 : timeout_reg);

    assign sfifo_rd_o = rd_reg;
    assign dout_o     = dout_reg;
    assign busy_o     = (state_reg != IDLE);
    assign timeout_o  = timeout_reg;
    assign cmd_cnt_o  = cnt_reg;

endmodule

// File: tb/tb_sfifo_cmd_sched.sv
// ---------------------------------------------------------------------------
// tb_sfifo_cmd_sched
//
// Scoreboard bench for sfifo_cmd_sched. Commands are pushed into a modelled
// show-ahead FIFO; a reference model predicts, per completed command, the
// dout pattern, the sticky timeout flag and the command count. A monitor
// compares those whenever cmd_cnt_o advances. Directed sections cover the
// edge timing; a random section mixes all four command types.
// ---------------------------------------------------------------------------
module tb_sfifo_cmd_sched;

    localparam int TIMEOUT = 20;
    localparam int CNT_W   = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             enable = 1'b0;
    logic             clr = 1'b0;
    logic             sfifo_rd;
    logic             sfifo_empty = 1'b1;
    logic [15:0]      sfifo_di = 16'h0000;
    logic             bp_tick;
    logic [15:0]      din = 16'h0000;
    logic [7:0]       dout;
    logic             busy;
    logic             timeout;
    logic [CNT_W-1:0] cmd_cnt;

    // Base-period tick is either free-running random or manually driven.
    logic             bp_auto = 1'b0;
    logic             bp_rand = 1'b0;
    logic             bp_man  = 1'b0;
    assign bp_tick = bp_auto ? bp_rand : bp_man;

    int vectors     = 0;
    int miscompares = 0;
    int pops        = 0;

    logic [15:0] fifo_q[$];

    typedef struct {
        logic [7:0]       dout;
        logic             to;
        logic [CNT_W-1:0] cnt;
    } exp_t;
    exp_t sb_q[$];

    // Reference model state
    logic [7:0]       m_dout    = 8'h00;
    logic             m_timeout = 1'b0;
    logic [CNT_W-1:0] m_cnt     = '0;

    sfifo_cmd_sched #(
        .SFIFO_DW (16),
        .TIMEOUT  (TIMEOUT),
        .TO_W     (16),
        .CNT_W    (CNT_W)
    ) dut (
        .wb_clk_i        (clk),
        .wb_rst_ni       (rst_n),
        .enable_i        (enable),
        .clr_i           (clr),
        .sfifo_rd_o      (sfifo_rd),
        .sfifo_empty_i   (sfifo_empty),
        .sfifo_di        (sfifo_di),
        .sfifo_bp_tick_i (bp_tick),
        .din_i           (din),
        .dout_o          (dout),
        .busy_o          (busy),
        .timeout_o       (timeout),
        .cmd_cnt_o       (cmd_cnt)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fifo_refresh();
        sfifo_empty = (fifo_q.size() == 0);
        sfifo_di    = sfifo_empty ? 16'h0000 : fifo_q[0];
    endtask

    task automatic push_cmd(input logic [15:0] c);
        fifo_q.push_back(c);
        fifo_refresh();
    endtask

    // Predict the architectural effect of one command running to completion.
    task automatic expect_cmd(input logic [15:0] c, input logic will_to);
        exp_t e;
        case (c[15:14])
            2'b01:   m_dout[c[2:0]] = c[13];
            2'b11:   if (will_to) m_timeout = 1'b1;
            default: ;
        endcase
        m_cnt  = m_cnt + 1'b1;
        e.dout = m_dout;
        e.to   = m_timeout;
        e.cnt  = m_cnt;
        sb_q.push_back(e);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (!(fifo_q.size() == 0 && !busy && !sfifo_rd) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("idle_within_budget", 32'(fifo_q.size() == 0 && !busy && !sfifo_rd), 32'd1);
    endtask

    task automatic wait_busy(input int budget);
        int n = 0;
        while (!busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("busy_within_budget", 32'(busy), 32'd1);
    endtask

    // FIFO read side: pop once per cycle the strobe is seen.
    initial begin
        logic prev_rd = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_rd = 1'b0;
            end else begin
                if (sfifo_rd) begin
                    chk("no_back_to_back_pop", 32'(prev_rd), 32'd0);
                    chk("pop_from_nonempty", 32'(fifo_q.size() > 0), 32'd1);
                    if (fifo_q.size() > 0) void'(fifo_q.pop_front());
                    pops++;
                    fifo_refresh();
                end
                prev_rd = sfifo_rd;
            end
        end
    end

    // Random base-period tick generator.
    initial forever begin
        @(negedge clk);
        if ($urandom_range(0, 2) == 0) bp_rand = ~bp_rand;
    end

    // Completion monitor.
    initial begin
        logic [CNT_W-1:0] last = '0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                last = '0;
            end else if (cmd_cnt !== last) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_completion", 32'(cmd_cnt), 32'(last));
                end else begin
                    e = sb_q.pop_front();
                    chk("cmd_cnt", 32'(cmd_cnt), 32'(e.cnt));
                    chk("dout", 32'(dout), 32'(e.dout));
                    chk("timeout", 32'(timeout), 32'(e.to));
                    $display("completion cnt=%0d dout=%02h timeout=%0b", cmd_cnt, dout, timeout);
                end
                last = cmd_cnt;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [15:0] c;
    logic        will_to;
    int          n;
    int          pops0;

    initial begin
        fifo_refresh();

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_rd", 32'(sfifo_rd), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_cnt", 32'(cmd_cnt), 32'd0);
        rst_n  = 1'b1;
        enable = 1'b1;
        repeat (2) @(negedge clk);

        // Two DOUT commands: set then clear pin 3, two separate pops.
        pops0 = pops;
        push_cmd(16'h6003); expect_cmd(16'h6003, 1'b0);
        push_cmd(16'h4003); expect_cmd(16'h4003, 1'b0);
        wait_idle(50);
        chk("dout_pair_pops", 32'(pops - pops0), 32'd2);
        chk("dout_pair_final", 32'(dout), 32'h00);

        // WAIT_BP N=3 holds the following DOUT until the third rising edge.
        push_cmd(16'h8003); expect_cmd(16'h8003, 1'b0);
        push_cmd(16'h6000); expect_cmd(16'h6000, 1'b0);
        repeat (6) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            bp_man = 1'b1; repeat (3) @(negedge clk);
            bp_man = 1'b0; repeat (3) @(negedge clk);
        end
        chk("bp_two_edges_dout0", 32'(dout[0]), 32'd0);
        chk("bp_two_edges_busy", 32'(busy), 32'd1);
        bp_man = 1'b1;
        wait_idle(50);
        bp_man = 1'b0;

        // WAIT_BP N=0: pin 1 rises in the 4th cycle counting the pop cycle.
        push_cmd(16'h8000); expect_cmd(16'h8000, 1'b0);
        push_cmd(16'h6001); expect_cmd(16'h6001, 1'b0);
        n = 0;
        while (!sfifo_rd && n < 20) begin @(negedge clk); n++; end
        n = 1;
        while (!dout[1] && n < 20) begin @(negedge clk); n++; end
        chk("bp_zero_latency", 32'(n), 32'd4);
        wait_idle(50);

        // WAIT_DIN timeout with clr held high: set wins, then clr clears.
        din[5] = 1'b0;
        repeat (4) @(negedge clk);
        clr = 1'b1;
        push_cmd(16'hD005); expect_cmd(16'hD005, 1'b1);
        wait_busy(20);
        n = 0;
        while (busy && n < 100) begin n++; @(negedge clk); end
        chk("waitdin_busy_cycles", 32'(n), 32'(TIMEOUT + 1));
        @(negedge clk);
        chk("clr_after_set", 32'(timeout), 32'd0);
        clr = 1'b0;
        m_timeout = 1'b0;

        // Next command still runs after a timeout.
        push_cmd(16'h6004); expect_cmd(16'h6004, 1'b0);
        wait_idle(50);

        // Match arriving in the last evaluated cycle beats the timeout.
        push_cmd(16'hD005); expect_cmd(16'hD005, 1'b0);
        wait_busy(20);
        repeat (18) @(negedge clk);
        din[5] = 1'b1;
        wait_idle(100);
        din[5] = 1'b0;
        repeat (4) @(negedge clk);

        // One cycle later the timeout fires first.
        push_cmd(16'hD005); expect_cmd(16'hD005, 1'b1);
        wait_busy(20);
        repeat (19) @(negedge clk);
        din[5] = 1'b1;
        wait_idle(100);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_pulse", 32'(timeout), 32'd0);
        m_timeout = 1'b0;

        // Abort a long WAIT_BP by dropping enable; nothing pops while low.
        push_cmd(16'h80FF);
        push_cmd(16'h6002);
        repeat (6) @(negedge clk);
        chk("abort_pre_busy", 32'(busy), 32'd1);
        enable = 1'b0;
        @(negedge clk);
        chk("abort_idle", 32'(busy), 32'd0);
        chk("abort_cnt", 32'(cmd_cnt), 32'(m_cnt));
        repeat (8) @(negedge clk);
        chk("abort_no_pop", 32'(fifo_q.size()), 32'd1);
        enable = 1'b1;
        expect_cmd(16'h6002, 1'b0);
        wait_idle(50);

        // Random mix with constant DIN so WAIT_DIN outcomes are decidable.
        bp_auto = 1'b1;
        din = 16'($urandom);
        repeat (4) @(negedge clk);
        for (int b = 0; b < 25; b++) begin
            for (int k = 0; k < int'($urandom_range(1, 8)); k++) begin
                c = 16'($urandom);
                case ($urandom_range(0, 3))
                    0: c[15:14] = 2'b00;
                    1: c[15:14] = 2'b01;
                    2: begin c[15:14] = 2'b10; c[7:0] = 8'($urandom_range(0, 5)); end
                    default: c[15:14] = 2'b11;
                endcase
                will_to = (c[15:14] == 2'b11) && (din[c[3:0]] != c[12]);
                push_cmd(c);
                expect_cmd(c, will_to);
            end
            wait_idle(1500);
        end
        bp_auto = 1'b0;

        // Asynchronous reset in the middle of a WAIT_DIN with all pins high.
        for (int p = 0; p < 8; p++) begin
            c = 16'h6000 | 16'(p);
            push_cmd(c); expect_cmd(c, 1'b0);
        end
        wait_idle(100);
        chk("all_pins_high", 32'(dout), 32'hFF);
        din[5] = 1'b0;
        repeat (4) @(negedge clk);
        push_cmd(16'hD005);
        repeat (6) @(negedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_dout", 32'(dout), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_timeout", 32'(timeout), 32'd0);
        chk("async_rst_cnt", 32'(cmd_cnt), 32'd0);
        chk("async_rst_rd", 32'(sfifo_rd), 32'd0);
        sb_q.delete();
        fifo_q.delete();
        fifo_refresh();
        m_dout = 8'h00; m_timeout = 1'b0; m_cnt = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_idle", 32'(busy), 32'd0);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
